// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, ID branch flushes,
// and multi-cycle data-memory waits with timeout. Stage controls are combinational (_c_o).
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             idex_mem_read_i,
  input  logic [4:0]       idex_rt_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  input  logic             branch_taken_i,
  input  logic             exmem_mem_access_i,
  input  logic             mem_ready_i,
  output logic             mem_req_c_o,
  output logic             pc_we_c_o,
  output logic             ifid_we_c_o,
  output logic             idex_we_c_o,
  output logic             exmem_we_c_o,
  output logic             memwb_we_c_o,
  output logic             ifid_flush_c_o,
  output logic             idex_bubble_c_o,
  output logic             mem_error_o,
  output logic [CNT_W-1:0] stall_count_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_error_q, mem_error_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                load_use;
  logic                hold_all;

  assign load_use = idex_mem_read_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    mem_error_d     = mem_error_q;
    hold_all        = 1'b0;
    mem_req_c_o     = 1'b0;
    pc_we_c_o       = 1'b1;
    ifid_we_c_o     = 1'b1;
    idex_we_c_o     = 1'b1;
    exmem_we_c_o    = 1'b1;
    memwb_we_c_o    = 1'b1;
    ifid_flush_c_o  = 1'b0;
    idex_bubble_c_o = 1'b0;

    // Memory handshake has priority; a release falls through to the hazard cases.
    case (state_q)
      ST_RUN: begin
        if (exmem_mem_access_i) begin
          mem_req_c_o = 1'b1;
          if (!mem_ready_i) begin
            hold_all   = 1'b1;
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end
        end
      end
      ST_MEM_WAIT: begin
        mem_req_c_o = 1'b1;
        if (mem_ready_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d     = ST_RUN;
          wait_cnt_d  = '0;
          mem_error_d = 1'b1;
        end else begin
          hold_all   = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (hold_all) begin
      pc_we_c_o    = 1'b0;
      ifid_we_c_o  = 1'b0;
      idex_we_c_o  = 1'b0;
      exmem_we_c_o = 1'b0;
      memwb_we_c_o = 1'b0;
    end else if (load_use) begin
      // Branch is dropped here; it re-resolves once the load has moved on.
      pc_we_c_o       = 1'b0;
      ifid_we_c_o     = 1'b0;
      idex_bubble_c_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_c_o = 1'b1;
    end

    if (!rst_ni) begin
      mem_req_c_o     = 1'b0;
      pc_we_c_o       = 1'b0;
      ifid_we_c_o     = 1'b0;
      idex_we_c_o     = 1'b0;
      exmem_we_c_o    = 1'b0;
      memwb_we_c_o    = 1'b0;
      ifid_flush_c_o  = 1'b0;
      idex_bubble_c_o = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_we_c_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign mem_error_o   = mem_error_q;
  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl against a cycle-level rule model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned T     = 4;
  localparam int unsigned CW    = 4;
  localparam int          MAXC  = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       memread, uses_rt, br, acc, rdy;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       req, pc_we, ifid_we, idex_we, exmem_we, memwb_we, flush, bubble, err;
  logic [CW-1:0] cnt;
  logic [7:0] dut_vec;
  logic [7:0] exp;

  int checks = 0;
  int errors = 0;

  // Reference model: request age in cycles, sticky error, stall count.
  bit m_wait;
  int m_age;
  bit m_err;
  int m_cnt;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .idex_mem_read_i(memread), .idex_rt_i(idex_rt), .ifid_rs_i(ifid_rs),
    .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(uses_rt), .branch_taken_i(br),
    .exmem_mem_access_i(acc), .mem_ready_i(rdy),
    .mem_req_c_o(req), .pc_we_c_o(pc_we), .ifid_we_c_o(ifid_we), .idex_we_c_o(idex_we),
    .exmem_we_c_o(exmem_we), .memwb_we_c_o(memwb_we), .ifid_flush_c_o(flush),
    .idex_bubble_c_o(bubble), .mem_error_o(err), .stall_count_o(cnt)
  );

  always #5 clk = ~clk;

  assign dut_vec = {req, pc_we, ifid_we, idex_we, exmem_we, memwb_we, flush, bubble};

  // {req, pc, ifid, idex, exmem, memwb, flush, bubble}
  function automatic logic [7:0] model_out();
    bit lu, hold, rq;
    if (!rst_n) return 8'h00;
    lu = memread && (idex_rt != 0) && ((idex_rt == ifid_rs) || (uses_rt && (idex_rt == ifid_rt)));
    if (!m_wait) begin
      rq = acc;
      hold = acc && !rdy;
    end else begin
      rq = 1'b1;
      hold = !rdy && (m_age < int'(T) - 1);
    end
    return {rq, !hold && !lu, !hold && !lu, !hold, !hold, !hold,
            !hold && !lu && br, !hold && lu};
  endfunction

  task automatic model_tick();
    logic [7:0] e;
    e = model_out();
    if (!e[6] && m_cnt < MAXC) m_cnt++;
    if (m_wait) begin
      if (rdy) m_wait = 0;
      else if (m_age == int'(T) - 1) begin m_wait = 0; m_err = 1; end
      else m_age++;
    end else if (acc && !rdy) begin
      m_wait = 1;
      m_age  = 1;
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rt_x, input logic [4:0] rs,
                        input logic [4:0] rt_d, input logic ur, input logic b,
                        input logic a, input logic r);
    memread = mr; idex_rt = rt_x; ifid_rs = rs; ifid_rt = rt_d;
    uses_rt = ur; br = b; acc = a; rdy = r;
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    m_wait = 0; m_age = 0; m_err = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(1, 5, 5, 0, 0, 1, 1, 0);
    #2;
    checks++;
    if (dut_vec !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec, 8'h00); end
    checks++;
    if (cnt !== 0 || err !== 1'b0) begin errors++; $display("FAIL reset_regs cnt=%0d err=%b exp 0/0", cnt, err); end
    do_reset();
  endtask

  task automatic test_no_hazard();
    for (int i = 0; i < 30; i++) begin
      set_in(0, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 0, 0, 1'($urandom));
      @(negedge clk);
      checks++;
      if (dut_vec !== 8'b0111_1100) begin errors++; $display("FAIL no_hazard[%0d] got=%b exp=%b", i, dut_vec, 8'b0111_1100); end
      step();
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL no_hazard_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1, 5, 5, 9, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0001_1101) begin errors++; $display("FAIL lu_stall got=%b exp=%b", dut_vec, 8'b0001_1101); end
    step();
    set_in(0, 5, 5, 9, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0111_1100) begin errors++; $display("FAIL lu_after got=%b exp=%b", dut_vec, 8'b0111_1100); end
    checks++;
    if (cnt !== 1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", cnt); end
    step();
    set_in(1, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0111_1100) begin errors++; $display("FAIL lu_rt0 got=%b exp=%b", dut_vec, 8'b0111_1100); end
    step();
    set_in(1, 5, 3, 5, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0111_1100) begin errors++; $display("FAIL lu_rt_unused got=%b exp=%b", dut_vec, 8'b0111_1100); end
    step();
    set_in(1, 5, 3, 5, 1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0001_1101) begin errors++; $display("FAIL lu_rt_used got=%b exp=%b", dut_vec, 8'b0001_1101); end
    step();
  endtask

  task automatic test_branch();
    do_reset();
    set_in(0, 5, 5, 0, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0111_1110) begin errors++; $display("FAIL br_flush got=%b exp=%b", dut_vec, 8'b0111_1110); end
    step();
    set_in(1, 7, 7, 0, 0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0001_1101) begin errors++; $display("FAIL br_with_lu got=%b exp=%b", dut_vec, 8'b0001_1101); end
    step();
  endtask

  task automatic test_multicycle();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, (i == 3));
      @(negedge clk);
      exp = (i == 3) ? 8'b1111_1100 : 8'b1000_0000;
      checks++;
      if (dut_vec !== exp) begin errors++; $display("FAIL mc_cycle[%0d] got=%b exp=%b", i, dut_vec, exp); end
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (cnt !== 3 || err !== 1'b0 || req !== 1'b0) begin
      errors++; $display("FAIL mc_done cnt=%0d err=%b req=%b exp 3/0/0", cnt, err, req);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < int'(T); i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      exp = (i == int'(T) - 1) ? 8'b1111_1100 : 8'b1000_0000;
      checks++;
      if (dut_vec !== exp || err !== 1'b0) begin
        errors++; $display("FAIL to_cycle[%0d] got=%b err=%b exp=%b err=0", i, dut_vec, err, exp);
      end
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || cnt !== 3) begin errors++; $display("FAIL to_err err=%b cnt=%0d exp 1/3", err, cnt); end
    step();
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL to_sticky err=%b exp=1", err); end
    do_reset();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL to_clear err=%b exp=0", err); end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 8'h00) begin errors++; $display("FAIL rst_mid got=%b exp=%b", dut_vec, 8'h00); end
    m_wait = 0; m_age = 0; m_err = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (dut_vec !== 8'b0111_1100 || cnt !== 0) begin
      errors++; $display("FAIL rst_mid_after got=%b cnt=%0d exp=%b cnt=0", dut_vec, cnt, 8'b0111_1100);
    end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(1, 4, 4, 0, 0, 0, 0, 0);
    repeat (20) step();
    checks++;
    if (cnt !== 4'(MAXC)) begin errors++; $display("FAIL sat_cnt got=%0d exp=%0d", cnt, MAXC); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      @(negedge clk);
      exp = model_out();
      checks++;
      if (dut_vec !== exp) begin errors++; $display("FAIL rand_out[%0d] got=%b exp=%b", i, dut_vec, exp); end
      checks++;
      if (cnt !== 4'(m_cnt) || err !== m_err) begin
        errors++; $display("FAIL rand_regs[%0d] cnt=%0d err=%b exp cnt=%0d err=%b", i, cnt, err, m_cnt, m_err);
      end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_no_hazard();
    test_load_use();
    test_branch();
    test_multicycle();
    test_timeout();
    test_reset_midwait();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage pipeline. Drives the WriteEnable inputs of the PC and the IFID, IDEX, EXMEM and MEMWB stage registers, and inserts bubbles and flushes for three cases: load-use hazards, taken branches resolved in ID, and multi-cycle data-memory accesses. The memory case uses a request/ready handshake with a timeout. The block also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum cycles spent in MEM_WAIT before forced release (must be ≥2).
- CNT_W, 16: width of Stall_Count.

Ports:
- Clock  in  1  rising-edge system clock.
- Reset  in  1  asynchronous, active-low reset.
- IDEX_MemRead  in  1  the instruction in EX is a load.
- IDEX_Rt  in  5  destination register of the load in EX.
- IFID_Rs  in  5  source register rs of the instruction in ID.
- IFID_Rt  in  5  source register rt of the instruction in ID.
- IFID_UsesRt  in  1  the ID instruction reads rt.
- Branch_Taken  in  1  branch/jump in ID resolved taken this cycle.
- EXMEM_MemAccess  in  1  the instruction in MEM is a load or store.
- Mem_Ready  in  1  data memory completes the access this cycle.
- Mem_Req  out  1  data-memory access request.
- PC_WE, IFID_WE, IDEX_WE, EXMEM_WE, MEMWB_WE  out  1 each  stage register write enables.
- IFID_Flush  out  1  load a NOP into IFID at this edge.
- IDEX_Bubble  out  1  load zeroed controls (a bubble) into IDEX at this edge.
- Mem_Error  out  1  sticky flag: a memory timeout occurred.
- Stall_Count  out  CNT_W  count of cycles with PC_WE=0, saturating.

## Operation
- FSM states: RUN, MEM_WAIT. Registered state: state, wait_cnt, Mem_Error, Stall_Count. All other outputs are combinational.
- While Reset=0:
  - state=RUN, wait_cnt=0, Mem_Error=0, Stall_Count=0.
  - All WE, Mem_Req, IFID_Flush and IDEX_Bubble are forced to 0.
- Cases are evaluated in RUN in this priority order, highest first:
  1. **Memory access**: EXMEM_MemAccess=1 → Mem_Req=1.
     - If Mem_Ready=1 in the same cycle: single-cycle access; fall through to the cases below.
     - Otherwise: all five WE=0, IFID_Flush=0, IDEX_Bubble=0; next state MEM_WAIT with wait_cnt=1.
  2. **Load-use**: IDEX_MemRead=1 and IDEX_Rt≠0 and (IDEX_Rt==IFID_Rs or (IFID_UsesRt=1 and IDEX_Rt==IFID_Rt)).
     - PC_WE=0, IFID_WE=0.
     - IDEX_WE=1 with IDEX_Bubble=1.
     - EXMEM_WE=1, MEMWB_WE=1.
     - Branch_Taken is ignored this cycle; the branch re-resolves after the stall.
  3. **Branch**: Branch_Taken=1 → all WE=1, IFID_Flush=1.
  4. **Otherwise**: all WE=1; flush and bubble 0.
- MEM_WAIT:
  - Mem_Req=1. All WE=0 unless released.
  - Mem_Ready=1 → release: all WE=1, then hazard cases 2–4 are evaluated as in RUN; next state RUN, wait_cnt=0.
  - Mem_Ready=0 and wait_cnt==MEM_TIMEOUT-1 → forced release: same outputs as a Ready release; Mem_Error set to 1 (sticky until reset).
  - Otherwise wait_cnt increments.
- During a MEMWB hold, WB may rewrite the same register with the same value; this is acceptable.
- Stall_Count increments at each edge where PC_WE=0 and Reset=1. It holds at 2^CNT_W-1.

## Timing
- Every WE, flush and bubble output is combinational from the current state and inputs, and takes effect at the next rising edge.
- Single-cycle memory (Mem_Ready asserted with the request): no stall.
- N-cycle memory (Mem_Ready arrives N-1 cycles after Mem_Req rises): exactly N-1 stall cycles; the pipeline advances on the Ready cycle.
- Load-use hazard: exactly 1 stall cycle. On the following cycle the load is in MEM, so no hazard against it remains.
- Mem_Req rises in the first cycle EXMEM_MemAccess=1 and falls after the release edge.
- Mem_Error rises at the forced-release edge, i.e. MEM_TIMEOUT cycles after entering MEM_WAIT is counted from the request.
- Reset assertion mid-MEM_WAIT: outputs clear immediately (asynchronously), and state returns to RUN.

## Test plan
- **No hazards.** Random IFID/IDEX registers, IDEX_MemRead=0, EXMEM_MemAccess=0 → all WE=1 every cycle; Stall_Count stays 0.
- **Load-use hazard.**
  - IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5 → for one cycle PC_WE=IFID_WE=0 and IDEX_Bubble=1; next cycle all WE=1; Stall_Count=1.
  - Repeat with IDEX_Rt=0 → no stall.
  - Repeat with IFID_Rt=5 and IFID_UsesRt=0 → no stall.
- **Branch and load-use together.** Branch_Taken=1 with no hazard → IFID_Flush=1 for one cycle. Branch_Taken=1 together with a load-use hazard → IFID_Flush=0 and the load-use stall is applied.
- **Multi-cycle memory.** EXMEM_MemAccess=1 with Mem_Ready arriving 3 cycles later → 3 cycles with all WE=0 and Mem_Req=1; release on the Ready cycle; Stall_Count=3; Mem_Error=0.
- **Memory timeout.** MEM_TIMEOUT=4, Mem_Ready held 0 → forced release after 4 cycles; Mem_Error=1 and stays 1 through later accesses until Reset.
- **Reset and counter saturation.**
  - Assert Reset=0 while in MEM_WAIT → WE and Mem_Req drop to 0 immediately; after release, state is RUN and Stall_Count=0.
  - CNT_W=4 with 20 stall cycles → Stall_Count=15.
